l2_mem_bridge: RTL and testbench

//  Sits directly downstream of the L1 data cache miss path. Accepts single-word L2 read/write

---
 rtl/l2_mem_bridge_pkg.sv | 21 ++
 rtl/l2_mem_bridge_if.sv | 37 +++
 rtl/l2_mem_bridge_wbuf_fifo.sv | 68 ++++++
 rtl/l2_mem_bridge.sv | 169 ++++++++++++++++
 tb/tb_l2_mem_bridge.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_mem_bridge_pkg.sv
// Shared types and default sizes for the L2 memory bridge and its write buffer.
package l2_bridge_pkg;

    localparam int unsigned L2_ADDR_W     = 32;
    localparam int unsigned L2_DATA_W     = 32;
    localparam int unsigned L2_WBUF_DEPTH = 4;
    localparam int unsigned L2_WADDR_W    = L2_ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        FWD     = 2'd3
    } state_t;

    typedef struct packed {
        logic [L2_WADDR_W-1:0] word_addr;
        logic [L2_DATA_W-1:0]  data;
    } wbuf_entry_t;

endpackage

// File: rtl/l2_mem_bridge_if.sv
// Cache-side request/response and memory-side req/ack signals of the L2 bridge.
interface l2_mem_bridge_if
    import l2_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = L2_ADDR_W,
    parameter int unsigned DATA_W = L2_DATA_W
);
    logic              l2_mem_en;
    logic              l2_mem_wr_en;
    logic [ADDR_W-1:0] l2_mem_access_addr;
    logic [DATA_W-1:0] l2_mem_wr_data;
    logic [DATA_W-1:0] l2_mem_rd_data;
    logic              l2_rd_valid;
    logic              l2_busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // The bridge: serves cache requests and masters the memory port
    modport slave (
        input  l2_mem_en, l2_mem_wr_en, l2_mem_access_addr, l2_mem_wr_data,
        input  mem_ack, mem_rdata,
        output l2_mem_rd_data, l2_rd_valid, l2_busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    // Cache plus memory environment around the bridge
    modport master (
        output l2_mem_en, l2_mem_wr_en, l2_mem_access_addr, l2_mem_wr_data,
        output mem_ack, mem_rdata,
        input  l2_mem_rd_data, l2_rd_valid, l2_busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/l2_mem_bridge_wbuf_fifo.sv
// Circular write buffer with a parallel youngest-match word-address search for read forwarding.
module l2_wbuf_fifo
    import l2_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = L2_WBUF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  wbuf_entry_t             push_entry,
    input  logic                    pop,
    input  logic [L2_WADDR_W-1:0]   lookup_addr,
    output logic                    full_c,
    output logic                    empty_c,
    output wbuf_entry_t             head_c,
    output logic                    hit_c,
    output logic [L2_DATA_W-1:0]    hit_data_c,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wbuf_entry_t      entry_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] idx;

    // Entry storage needs no reset; validity is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[wr_ptr_q] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Walk oldest to youngest so the youngest matching entry overrides
    always_comb begin
        hit_c      = 1'b0;
        hit_data_c = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (entry_q[idx].word_addr == lookup_addr)) begin
                hit_c      = 1'b1;
                hit_data_c = entry_q[idx].data;
            end
        end
    end

    assign head_c  = entry_q[rd_ptr_q];
    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/l2_mem_bridge.sv
// L2 bridge: posts cache writes into a buffer, forwards buffered read hits, and
// sequences miss reads and buffer drains onto a req/ack main-memory port.
module l2_mem_bridge
    import l2_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W     = L2_ADDR_W,
    parameter int unsigned DATA_W     = L2_DATA_W,
    parameter int unsigned WBUF_DEPTH = L2_WBUF_DEPTH
) (
    input logic            clk,
    input logic            rst_n,
    l2_mem_bridge_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WBUF_DEPTH) + 1;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-3:0] pend_addr_q, pend_addr_d;

    logic              accept_wr, accept_rd, fwd_hit, pop;
    wbuf_entry_t       push_entry, head, drain;
    logic              full, empty, hit;
    logic [DATA_W-1:0] hit_data;
    logic [CNT_W-1:0]  count;
    logic              unused_addr_bits;

    assign accept_wr        = bus.l2_mem_en &  bus.l2_mem_wr_en & ~busy_q;
    assign accept_rd        = bus.l2_mem_en & ~bus.l2_mem_wr_en & ~busy_q;
    assign fwd_hit          = accept_rd & hit;
    assign pop              = (state_q == WR_WAIT) & bus.mem_ack;
    assign unused_addr_bits = ^bus.l2_mem_access_addr[1:0];

    always_comb begin
        push_entry.word_addr = bus.l2_mem_access_addr[ADDR_W-1:2];
        push_entry.data      = bus.l2_mem_wr_data;
    end

    l2_wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept_wr),
        .push_entry (push_entry),
        .pop        (pop),
        .lookup_addr(bus.l2_mem_access_addr[ADDR_W-1:2]),
        .full_c     (full),
        .empty_c    (empty),
        .head_c     (head),
        .hit_c      (hit),
        .hit_data_c (hit_data),
        .count      (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        // An empty buffer drains the write being accepted this cycle directly
        drain       = empty ? push_entry : head;

        // Buffer hits answer the cache without touching memory, even mid-drain
        if (fwd_hit) begin
            rd_data_d  = hit_data;
            rd_valid_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pend_q || (accept_rd && !hit)) begin
                    state_d    = RD_WAIT;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pend_q ? {pend_addr_q, 2'b00}
                                        : {bus.l2_mem_access_addr[ADDR_W-1:2], 2'b00};
                    pend_d     = 1'b0;
                end else if (fwd_hit) begin
                    state_d = FWD;
                end else if (!empty || accept_wr) begin
                    state_d     = WR_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {drain.word_addr, 2'b00};
                    mem_wdata_d = drain.data;
                end
            end
            RD_WAIT: begin
                if (bus.mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    rd_data_d  = bus.mem_rdata;
                    rd_valid_d = 1'b1;
                end
            end
            WR_WAIT: begin
                // A missing read parks here and issues ahead of the next drain
                if (accept_rd && !hit) begin
                    pend_d      = 1'b1;
                    pend_addr_d = bus.l2_mem_access_addr[ADDR_W-1:2];
                end
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            FWD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A same-cycle pop only frees a slot on the following cycle
        busy_d = (full && !pop)
               || (accept_wr && !pop && (count == CNT_W'(WBUF_DEPTH - 1)))
               || rd_valid_d || pend_d
               || (state_d == RD_WAIT) || (state_d == FWD);
    end

    assign bus.mem_req        = mem_req_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.l2_mem_rd_data = rd_data_q;
    assign bus.l2_rd_valid    = rd_valid_q;
    assign bus.l2_busy        = busy_q;

endmodule

// File: tb/tb_l2_mem_bridge.sv
// Directed self-checking bench for l2_mem_bridge with a small memory and reference model.
module tb_l2_mem_bridge;
    import l2_bridge_pkg::*;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    bit   auto_mem;
    logic [31:0] mmem  [int unsigned];
    logic [31:0] rmodel[int unsigned];

    l2_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    l2_mem_bridge dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mget(input int unsigned a);
        return mmem.exists(a) ? mmem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rget(input int unsigned a);
        return rmodel.exists(a) ? rmodel[a] : 32'h0;
    endfunction

    // One cycle; when enabled the memory model acks any outstanding request immediately
    task automatic tick();
        if (auto_mem && bus.mem_req) begin
            if (bus.mem_we) mmem[bus.mem_addr] = bus.mem_wdata;
            else            bus.mem_rdata = mget(bus.mem_addr);
            bus.mem_ack = 1'b1;
        end
        step();
        bus.mem_ack = 1'b0;
    endtask

    task automatic cache_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bus.l2_mem_en          = 1'b1;
        bus.l2_mem_wr_en       = wr;
        bus.l2_mem_access_addr = addr;
        bus.l2_mem_wr_data     = data;
        step();
        bus.l2_mem_en = 1'b0;
    endtask

    task automatic ack_step(input logic [31:0] rdata);
        bus.mem_rdata = rdata;
        bus.mem_ack   = 1'b1;
        step();
        bus.mem_ack   = 1'b0;
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (bus.l2_busy && n < 50) begin tick(); n++; end
        chk("busy_timeout", 32'(bus.l2_busy), 32'h0);
    endtask

    task automatic op_wr(input logic [31:0] addr, input logic [31:0] data);
        wait_not_busy();
        rmodel[{addr[31:2], 2'b00}] = data;
        bus.l2_mem_en = 1'b1; bus.l2_mem_wr_en = 1'b1;
        bus.l2_mem_access_addr = addr; bus.l2_mem_wr_data = data;
        tick();
        bus.l2_mem_en = 1'b0;
    endtask

    task automatic op_rd(input logic [31:0] addr);
        int n = 0;
        wait_not_busy();
        bus.l2_mem_en = 1'b1; bus.l2_mem_wr_en = 1'b0;
        bus.l2_mem_access_addr = addr;
        tick();
        bus.l2_mem_en = 1'b0;
        while (!bus.l2_rd_valid && n < 50) begin tick(); n++; end
        chk("rand_rd_valid", 32'(bus.l2_rd_valid), 32'h1);
        chk($sformatf("rand_rd_data@%0h", addr), bus.l2_mem_rd_data, rget({addr[31:2], 2'b00}));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_req"},  32'(bus.mem_req), 32'h0);
        chk({tag, "_mem_we"},   32'(bus.mem_we), 32'h0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, "_rd_data"},  bus.l2_mem_rd_data, 32'h0);
        chk({tag, "_rd_valid"}, 32'(bus.l2_rd_valid), 32'h0);
        chk({tag, "_busy"},     32'(bus.l2_busy), 32'h0);
    endtask

    initial begin
        n_assert = 0; n_fail = 0; auto_mem = 1'b0;
        rst_n = 1'b0;
        bus.l2_mem_en = 1'b0; bus.l2_mem_wr_en = 1'b0;
        bus.l2_mem_access_addr = '0; bus.l2_mem_wr_data = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // Reset state
        step(); step();
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        step();

        // Test 1: single posted write drained to memory
        cache_req(1'b1, 32'h100, 32'hDEADBEEF);
        chk("t1_req", 32'(bus.mem_req), 32'h1);
        chk("t1_we", 32'(bus.mem_we), 32'h1);
        chk("t1_addr", bus.mem_addr, 32'h100);
        chk("t1_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("t1_busy", 32'(bus.l2_busy), 32'h0);
        step(); step();
        chk("t1_req_held", 32'(bus.mem_req), 32'h1);
        chk("t1_addr_held", bus.mem_addr, 32'h100);
        ack_step(32'h0);
        chk("t1_req_done", 32'(bus.mem_req), 32'h0);
        chk("t1_empty", 32'(dut.u_wbuf.empty_c), 32'h1);
        step();
        chk("t1_no_redrain", 32'(bus.mem_req), 32'h0);
        chk("t1_busy_end", 32'(bus.l2_busy), 32'h0);

        // Test 2: fill buffer with memory stalled, overflow write dropped, drain order
        cache_req(1'b1, 32'h0, 32'hA0);
        cache_req(1'b1, 32'h4, 32'hA4);
        cache_req(1'b1, 32'h8, 32'hA8);
        chk("t2_busy_3", 32'(bus.l2_busy), 32'h0);
        cache_req(1'b1, 32'hC, 32'hAC);
        chk("t2_busy_4", 32'(bus.l2_busy), 32'h1);
        cache_req(1'b1, 32'h10, 32'hB0);
        chk("t2_busy_5", 32'(bus.l2_busy), 32'h1);
        chk("t2_drain0_addr", bus.mem_addr, 32'h0);
        chk("t2_drain0_data", bus.mem_wdata, 32'hA0);
        ack_step(32'h0);
        chk("t2_busy_drop", 32'(bus.l2_busy), 32'h0);
        step();
        chk("t2_drain1_addr", bus.mem_addr, 32'h4);
        chk("t2_drain1_data", bus.mem_wdata, 32'hA4);
        ack_step(32'h0); step();
        chk("t2_drain2_addr", bus.mem_addr, 32'h8);
        ack_step(32'h0); step();
        chk("t2_drain3_addr", bus.mem_addr, 32'hC);
        chk("t2_drain3_data", bus.mem_wdata, 32'hAC);
        ack_step(32'h0); step();
        chk("t2_no_fifth", 32'(bus.mem_req), 32'h0);

        // Test 3: read forwarded from youngest buffered write while memory stalled
        cache_req(1'b1, 32'h200, 32'h11);
        cache_req(1'b1, 32'h200, 32'h22);
        cache_req(1'b0, 32'h203, 32'h0);
        chk("t3_valid", 32'(bus.l2_rd_valid), 32'h1);
        chk("t3_data", bus.l2_mem_rd_data, 32'h22);
        chk("t3_busy", 32'(bus.l2_busy), 32'h1);
        chk("t3_mem_still_write", 32'(bus.mem_we), 32'h1);
        step();
        chk("t3_valid_pulse", 32'(bus.l2_rd_valid), 32'h0);
        chk("t3_busy_clear", 32'(bus.l2_busy), 32'h0);
        chk("t3_data_held", bus.l2_mem_rd_data, 32'h22);
        ack_step(32'h0); step();
        chk("t3_drain2_data", bus.mem_wdata, 32'h22);
        ack_step(32'h0); step();
        chk("t3_idle", 32'(bus.mem_req), 32'h0);

        // Test 4: miss read waits for the outstanding drain, then beats the second drain
        cache_req(1'b1, 32'h400, 32'h1);
        cache_req(1'b1, 32'h404, 32'h2);
        cache_req(1'b0, 32'h300, 32'h0);
        chk("t4_busy", 32'(bus.l2_busy), 32'h1);
        chk("t4_no_valid", 32'(bus.l2_rd_valid), 32'h0);
        chk("t4_first_drain", bus.mem_addr, 32'h400);
        ack_step(32'h0);
        step();
        chk("t4_rd_req", 32'(bus.mem_req), 32'h1);
        chk("t4_rd_we", 32'(bus.mem_we), 32'h0);
        chk("t4_rd_addr", bus.mem_addr, 32'h300);
        ack_step(32'hCAFEF00D);
        chk("t4_valid", 32'(bus.l2_rd_valid), 32'h1);
        chk("t4_data", bus.l2_mem_rd_data, 32'hCAFEF00D);
        chk("t4_busy_valid", 32'(bus.l2_busy), 32'h1);
        step();
        chk("t4_busy_done", 32'(bus.l2_busy), 32'h0);
        chk("t4_second_drain", bus.mem_addr, 32'h404);
        chk("t4_second_we", 32'(bus.mem_we), 32'h1);
        ack_step(32'h0); step();
        chk("t4_idle", 32'(bus.mem_req), 32'h0);

        // Test 5: async reset during RD_WAIT, stray ack afterwards ignored
        cache_req(1'b0, 32'h500, 32'h0);
        chk("t5_rd_wait", 32'(bus.mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_outputs_zero("t5_rst");
        step();
        rst_n = 1'b1;
        ack_step(32'h1234);
        chk("t5_no_valid", 32'(bus.l2_rd_valid), 32'h0);
        chk("t5_no_req", 32'(bus.mem_req), 32'h0);
        step();
        chk("t5_no_valid2", 32'(bus.l2_rd_valid), 32'h0);
        chk("t5_state", 32'(dut.state_q), 32'(IDLE));

        // Test 6: write/read mix against a reference memory with an auto-acking memory
        auto_mem = 1'b1;
        op_wr(32'h1000, 32'hA1);
        op_wr(32'h1004, 32'hB2);
        op_rd(32'h1000);
        op_wr(32'h1000, 32'hC3);
        op_rd(32'h1001);
        op_rd(32'h1008);
        op_wr(32'h1008, 32'hD4);
        op_wr(32'h100C, 32'hE5);
        op_wr(32'h1008, 32'hF6);
        op_rd(32'h1008);
        op_rd(32'h1004);
        op_wr(32'h1010, 32'h77);
        op_wr(32'h1004, 32'h55);
        op_wr(32'h1014, 32'h99);
        op_rd(32'h100E);
        op_rd(32'h1004);
        for (int i = 0; i < 20; i++) tick();
        op_rd(32'h1010);
        op_rd(32'h1014);
        op_rd(32'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
